// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 read-cycle custom instruction (status/data reads, optional busy-flag polling).
// Define LCD_READ_SYNC_EN to pass db_in through a 2-flop synchronizer (EN_HIGH stretched by 2 cycles).
module lcd_reader #(
  parameter int T_SETUP   = 2,
  parameter int T_EN_HIGH = 25,
  parameter int T_EN_LOW  = 25,
  parameter int POLL_MAX  = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        rs,
  output logic        rw,
  output logic        en,
  input  logic [7:0]  db_in,
  output logic        bus_req
);
  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, EN_LOW, FINISH} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, ncyc_q, ncyc_d;
  logic [7:0]  data_q, data_d, db_s;
  logic        poll_q, poll_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d, rs_q, rs_d, rw_q, rw_d, en_q, en_d, bus_req_q, bus_req_d;
  logic        unused;
  assign unused = ^{dataa[31:2], datab};
`ifdef LCD_READ_SYNC_EN
  localparam int EH = T_EN_HIGH + 2;
  logic [7:0] sync1_q, sync2_q;
  // Free-running so the pad value is settled regardless of clk_en gaps.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= db_in;
      sync2_q <= sync1_q;
    end
  assign db_s = sync2_q;
`else
  localparam int EH = T_EN_HIGH;
  assign db_s = db_in;
`endif
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ncyc_d    = ncyc_q;
    data_d    = data_q;
    poll_d    = poll_q;
    result_d  = result_q;
    done_d    = done_q;
    rs_d      = rs_q;
    rw_d      = rw_q;
    en_d      = en_q;
    bus_req_d = bus_req_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          rs_d      = dataa[0];
          poll_d    = dataa[1] & ~dataa[0];
          rw_d      = 1'b1;
          bus_req_d = 1'b1;
          cnt_d     = '0;
          ncyc_d    = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(T_SETUP - 1)) begin
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = EN_HIGH;
        end
      end
      EN_HIGH: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(EH - 1)) begin
          cnt_d   = '0;
          data_d  = db_s;
          en_d    = 1'b0;
          ncyc_d  = ncyc_q + 16'd1;
          state_d = EN_LOW;
        end
      end
      EN_LOW: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(T_EN_LOW - 1)) begin
          cnt_d   = '0;
          state_d = (poll_q && data_q[7] && ncyc_q < 16'(POLL_MAX)) ? SETUP : FINISH;
        end
      end
      FINISH: begin
        result_d  = {ncyc_q, 7'b0, poll_q & data_q[7], data_q};
        done_d    = 1'b1;
        rw_d      = 1'b0;
        bus_req_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ncyc_q    <= '0;
      data_q    <= '0;
      poll_q    <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      en_q      <= 1'b0;
      bus_req_q <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ncyc_q    <= ncyc_d;
      data_q    <= data_d;
      poll_q    <= poll_d;
      result_q  <= result_d;
      done_q    <= done_d;
      rs_q      <= rs_d;
      rw_q      <= rw_d;
      en_q      <= en_d;
      bus_req_q <= bus_req_d;
    end
  assign result  = result_q;
  assign done    = done_q;
  assign rs      = rs_q;
  assign rw      = rw_q;
  assign en      = en_q;
  assign bus_req = bus_req_q;
endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: directed reads of lcd_reader with a result scoreboard and en/latency timing checks.
module tb_lcd_reader;
  localparam int T_SETUP = 2, T_EN_HIGH = 25, T_EN_LOW = 25, POLL_MAX = 5;
`ifdef LCD_READ_SYNC_EN
  localparam int EH = T_EN_HIGH + 2;
`else
  localparam int EH = T_EN_HIGH;
`endif
  localparam int LAT = T_SETUP + EH + T_EN_LOW + 1;
  logic clk = 0, reset_n = 0, clk_en = 1, start = 0;
  logic [31:0] dataa = 0, datab = 0, result;
  logic [7:0] db_in = 0;
  logic done, rs, rw, en, bus_req;
  bit gate = 0;
  int checks = 0, failures = 0;
  logic [31:0] sb[$];

  lcd_reader #(.T_SETUP(T_SETUP), .T_EN_HIGH(T_EN_HIGH), .T_EN_LOW(T_EN_LOW), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
    .result(result), .done(done), .rs(rs), .rw(rw), .en(en), .db_in(db_in), .bus_req(bus_req)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    clk_en = gate ? ~clk_en : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [7:0] busy_v,
                         input int n_busy, input logic [7:0] fin_v, input int exp_pulses,
                         input logic [31:0] exp);
    int mul, cyc, pulses, hi, first_rise;
    bit prev_en, ok;
    logic [31:0] got;
    mul = gate ? 2 : 1;
    cyc = 0; pulses = 0; hi = 0; first_rise = -1; prev_en = 0; ok = 1;
    sb.push_back(exp);
    db_in = (n_busy > 0) ? busy_v : fin_v;
    @(negedge clk);
    dataa = a;
    start = 1;
    for (int i = 0; i < 8 && bus_req !== 1'b1; i++) @(negedge clk);
    start = 0;
    chk({tag, "_accept"}, {31'b0, bus_req}, 1);
    while (done !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (gate && cyc == 20) begin start = 1; dataa = 32'h3; end
      if (gate && cyc == 26) start = 0;
      if (en && !prev_en) begin
        pulses++;
        if (first_rise < 0) first_rise = cyc;
        hi = 0;
      end
      if (en) hi++;
      if (prev_en && !en) begin
        chk({tag, "_en_high"}, hi, EH * mul);
        db_in = (pulses + 1 <= n_busy) ? busy_v : fin_v;
      end
      if (done !== 1'b1 && (rw !== 1'b1 || bus_req !== 1'b1 || rs !== a[0])) ok = 0;
      prev_en = en;
    end
    chk({tag, "_done"}, {31'b0, done}, 1);
    got = result;
    chk({tag, "_setup"}, first_rise, T_SETUP * mul);
    chk({tag, "_pulses"}, pulses, exp_pulses);
    chk({tag, "_bus_hold"}, {31'b0, ok}, 1);
    if (exp_pulses == 1) chk({tag, "_latency"}, cyc, LAT * mul);
    if (sb.size() > 0) chk({tag, "_result"}, got, sb.pop_front());
    repeat (mul) @(negedge clk);
    chk({tag, "_done_clr"}, {29'b0, done, rw, bus_req}, 0);
    repeat (6) @(negedge clk);
    chk({tag, "_idle_after"}, {30'b0, bus_req, en}, 0);
    chk({tag, "_result_hold"}, result, got);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'b0, done, rs, rw, en, bus_req}, 0);
    chk("reset_result", result, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);
    do_read("status",      32'h0, 8'h00, 0, 8'h25, 1, 32'h0001_0025);
    do_read("data",        32'h1, 8'h00, 0, 8'hA7, 1, 32'h0001_00A7);
    do_read("data_poll",   32'h3, 8'h00, 0, 8'hA7, 1, 32'h0001_00A7);
    do_read("status_busy", 32'h0, 8'h00, 0, 8'h80, 1, 32'h0001_0080);
    do_read("poll_clear",  32'h2, 8'h80, 3, 8'h0C, 4, 32'h0004_000C);
    do_read("poll_tmo",    32'h2, 8'hFF, 9, 8'hFF, POLL_MAX, 32'h0005_01FF);
    gate = 1;
    do_read("gated",       32'h0, 8'h00, 0, 8'h25, 1, 32'h0001_0025);
    gate = 0;
    repeat (4) @(negedge clk);
    db_in = 8'h55;
    dataa = 32'h0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 20 && en !== 1'b1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("rst_en_before", {31'b0, en}, 1);
    #2 reset_n = 0;
    #1;
    chk("rst_async_pins", {28'b0, done, rw, en, bus_req}, 0);
    chk("rst_async_result", result, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (60) @(negedge clk);
    chk("rst_no_done", {30'b0, done, bus_req}, 0);
    do_read("after_reset", 32'h1, 8'h00, 0, 8'h3C, 1, 32'h0001_003C);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
